// File: rtl/matrix_mem_responder.sv
// Matrix element store: no-stall op-engine read/write port, lower-priority host
// req/ack port, and a hardware clear sweep that zeroes every element.
module matrix_mem_responder #(
    parameter int unsigned ELEMENT_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DEPTH         = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_rd_en_i,
    input  logic [ADDR_WIDTH-1:0]    op_rd_addr_i,
    output logic [ELEMENT_WIDTH-1:0] op_rd_data_o,
    input  logic                     op_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]    op_wr_addr_i,
    input  logic [ELEMENT_WIDTH-1:0] op_wr_data_i,
    input  logic                     host_req_i,
    input  logic                     host_we_i,
    input  logic [ADDR_WIDTH-1:0]    host_addr_i,
    input  logic [ELEMENT_WIDTH-1:0] host_wdata_i,
    output logic                     host_ack_o,
    output logic [ELEMENT_WIDTH-1:0] host_rdata_o,
    input  logic                     clr_start_i,
    output logic                     clr_busy_o,
    output logic                     clr_done_o,
    output logic                     addr_err_o
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e                   state_q;
    logic [IdxW-1:0]          cnt_q;
    logic                     clr_busy_q, clr_done_q, addr_err_q, host_ack_q;
    logic [ELEMENT_WIDTH-1:0] op_rd_data_q, host_rdata_q;
    logic [ELEMENT_WIDTH-1:0] mem [DEPTH];

    logic                     op_rd_ok, op_wr_ok, host_ok, host_accept, err_set;
    logic                     mem_we;
    logic [IdxW-1:0]          mem_waddr;
    logic [ELEMENT_WIDTH-1:0] mem_wdata;

    assign op_rd_ok = 32'(op_rd_addr_i) < DEPTH;
    assign op_wr_ok = 32'(op_wr_addr_i) < DEPTH;
    assign host_ok  = 32'(host_addr_i) < DEPTH;

    // Host only gets a cycle the op engine leaves completely idle, and never back-to-back.
    assign host_accept = host_req_i & ~op_rd_en_i & ~op_wr_en_i &
                         (state_q == StIdle) & ~host_ack_q;

    assign err_set = (op_rd_en_i & ~op_rd_ok) | (op_wr_en_i & ~op_wr_ok) |
                     (host_accept & ~host_ok);

    // Single write port: op write beats the sweep (which then stalls), host only when accepted.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (op_wr_en_i) begin
            mem_we    = op_wr_ok;
            mem_waddr = op_wr_addr_i[IdxW-1:0];
            mem_wdata = op_wr_data_i;
        end else if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
        end else if (host_accept && host_we_i) begin
            mem_we    = host_ok;
            mem_waddr = host_addr_i[IdxW-1:0];
            mem_wdata = host_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rd_data_q <= '0;
            host_rdata_q <= '0;
            host_ack_q   <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            host_ack_q <= host_accept;
            if (op_rd_en_i) begin
                op_rd_data_q <= op_rd_ok ? mem[op_rd_addr_i[IdxW-1:0]] : '0;
            end
            if (host_accept && !host_we_i) begin
                host_rdata_q <= host_ok ? mem[host_addr_i[IdxW-1:0]] : '0;
            end
            if (err_set) begin
                addr_err_q <= 1'b1;
            end else if (state_q == StIdle && clr_start_i) begin
                addr_err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr_start_i) begin
                        state_q    <= StClear;
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                StClear: begin
                    if (!op_wr_en_i) begin
                        if (cnt_q == IdxW'(DEPTH - 1)) begin
                            state_q    <= StDone;
                            clr_busy_q <= 1'b0;
                            clr_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + IdxW'(1);
                        end
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state_q    <= StIdle;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign op_rd_data_o = op_rd_data_q;
    assign host_rdata_o = host_rdata_q;
    assign host_ack_o   = host_ack_q;
    assign clr_busy_o   = clr_busy_q;
    assign clr_done_o   = clr_done_q;
    assign addr_err_o   = addr_err_q;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Scoreboard bench for matrix_mem_responder with a 16-element store.
module tb_matrix_mem_responder;

    localparam int EW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_rd_en = 1'b0, op_wr_en = 1'b0;
    logic [AW-1:0] op_rd_addr = '0, op_wr_addr = '0, host_addr = '0;
    logic [EW-1:0] op_wr_data = '0, host_wdata = '0;
    logic          host_req = 1'b0, host_we = 1'b0, clr_start = 1'b0;
    logic [EW-1:0] op_rd_data, host_rdata;
    logic          host_ack, clr_busy, clr_done, addr_err;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [EW-1:0] model [DEPTH];
    logic [EW-1:0] exp_q [$];

    matrix_mem_responder #(
        .ELEMENT_WIDTH(EW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_rd_en_i  (op_rd_en),
        .op_rd_addr_i(op_rd_addr),
        .op_rd_data_o(op_rd_data),
        .op_wr_en_i  (op_wr_en),
        .op_wr_addr_i(op_wr_addr),
        .op_wr_data_i(op_wr_data),
        .host_req_i  (host_req),
        .host_we_i   (host_we),
        .host_addr_i (host_addr),
        .host_wdata_i(host_wdata),
        .host_ack_o  (host_ack),
        .host_rdata_o(host_rdata),
        .clr_start_i (clr_start),
        .clr_busy_o  (clr_busy),
        .clr_done_o  (clr_done),
        .addr_err_o  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] model_rd(input int a);
        return (a < DEPTH) ? model[a] : '0;
    endfunction

    task automatic op_write(input int a, input logic [EW-1:0] d);
        op_wr_en   = 1'b1;
        op_wr_addr = AW'(a);
        op_wr_data = d;
        step();
        op_wr_en = 1'b0;
        if (a < DEPTH) model[a] = d;
    endtask

    task automatic op_read(input string tag, input int a);
        op_rd_en   = 1'b1;
        op_rd_addr = AW'(a);
        exp_q.push_back(model_rd(a));
        step();
        op_rd_en = 1'b0;
        check(tag, {24'd0, op_rd_data}, {24'd0, exp_q.pop_front()});
    endtask

    task automatic host_access(input string tag, input logic we, input int a,
                               input logic [EW-1:0] d);
        int waited = 0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = AW'(a);
        host_wdata = d;
        if (!we) exp_q.push_back(model_rd(a));
        do begin
            step();
            waited++;
        end while (host_ack !== 1'b1 && waited < 50);
        host_req = 1'b0;
        check({tag, "_ack"}, {31'd0, host_ack}, 32'd1);
        if (we) begin
            if (a < DEPTH) model[a] = d;
        end else begin
            check({tag, "_rdata"}, {24'd0, host_rdata}, {24'd0, exp_q.pop_front()});
        end
    endtask

    // stall_at > 0 injects one op write (addr 3) in that busy cycle.
    task automatic run_sweep(input string tag, input int stall_at, input int exp_busy);
        int busy = 0;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        while (clr_busy === 1'b1 && busy < 100) begin
            busy++;
            if (busy == stall_at) begin
                op_wr_en   = 1'b1;
                op_wr_addr = AW'(3);
                op_wr_data = 8'h77;
            end
            step();
            op_wr_en = 1'b0;
        end
        check({tag, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
        check({tag, "_done"}, {31'd0, clr_done}, 32'd1);
        step();
        check({tag, "_done_pulse"}, {31'd0, clr_done}, 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        if (stall_at > 0) model[3] = 8'h77;
    endtask

    initial begin
        #2;
        check("rst_op_rd_data", {24'd0, op_rd_data}, 32'd0);
        check("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
        check("rst_host_ack", {31'd0, host_ack}, 32'd0);
        check("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
        check("rst_clr_done", {31'd0, clr_done}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Registered read, held across idle cycles
        op_write(5, 8'h3C);
        op_read("rd5", 5);
        repeat (3) step();
        check("rd5_held", {24'd0, op_rd_data}, 32'h3C);

        // Read-first on same-cycle address match
        op_write(7, 8'h11);
        op_rd_en   = 1'b1;
        op_rd_addr = AW'(7);
        exp_q.push_back(model[7]);
        op_write(7, 8'h22);
        op_rd_en = 1'b0;
        check("rd7_read_first", {24'd0, op_rd_data}, {24'd0, exp_q.pop_front()});
        op_read("rd7_new", 7);

        // Host blocked while op reads are active
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = AW'(9);
        host_wdata = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            op_rd_en   = 1'b1;
            op_rd_addr = AW'(5);
            exp_q.push_back(model[5]);
            step();
            check("host_blocked_ack", {31'd0, host_ack}, 32'd0);
            check("host_blocked_rd", {24'd0, op_rd_data}, {24'd0, exp_q.pop_front()});
        end
        op_rd_en = 1'b0;
        step();
        check("host_wr_ack", {31'd0, host_ack}, 32'd1);
        host_req = 1'b0;
        model[9] = 8'hA5;
        step();
        check("host_ack_pulse", {31'd0, host_ack}, 32'd0);
        host_access("host_rd9", 1'b0, 9, 8'h00);

        // Plain sweep over a fully populated store
        for (int i = 0; i < DEPTH; i++) op_write(i, 8'(i * 7 + 1));
        run_sweep("sweep", 0, DEPTH);
        for (int i = 0; i < DEPTH; i++) op_read("sweep_rd", i);

        // Sweep with one op write stalling it
        for (int i = 0; i < DEPTH; i++) op_write(i, 8'(i + 8'h80));
        run_sweep("sweep_stall", 8, DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) op_read("sweep_stall_rd", i);

        // Out-of-range accesses
        op_write(0, 8'h5A);
        op_write(DEPTH, 8'hFF);
        check("oor_wr_err", {31'd0, addr_err}, 32'd1);
        op_read("oor_no_alias", 0);
        op_read("oor_op_rd", DEPTH);
        host_access("oor_host_wr", 1'b1, DEPTH, 8'hEE);
        host_access("oor_host_rd", 1'b0, DEPTH, 8'h00);
        op_read("oor_no_alias2", 0);
        check("oor_err_sticky", {31'd0, addr_err}, 32'd1);
        run_sweep("oor_sweep", 0, DEPTH);
        check("oor_err_cleared", {31'd0, addr_err}, 32'd0);

        // Reset in the middle of a sweep
        for (int i = 0; i < DEPTH; i++) op_write(i, 8'(i + 8'h40));
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, clr_busy}, 32'd0);
        check("rst_mid_done", {31'd0, clr_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) model[i] = '0;
        step();
        check("rst_mid_idle", {31'd0, clr_busy}, 32'd0);
        for (int i = 0; i < DEPTH; i++) op_read("rst_mid_rd", i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
